// File: rtl/slsr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// slsr_pkg: shared types for the slsr loader.  Rev 1.0
// ---------------------------------------------------------------------
package slsr_pkg;

  localparam int SLSR_WIDTH = 8;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } shift_dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/slsr_loader.sv
`default_nettype none
// ---------------------------------------------------------------------
// slsr_loader: serialises a parallel word onto slsr sl/sr/din.  Rev 1.0
// ---------------------------------------------------------------------
module slsr_loader
  import slsr_pkg::*;
#(
  parameter int WIDTH = SLSR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             sl,
  output logic             sr,
  output logic             din,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  loader_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shadow;
  shift_dir_e       dir;

  assign in_ready = (state == IDLE) && !reset;

  // The shadow word shifts along with the register, so the next bit
  // to drive always sits next to the end that was just emitted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shadow <= '0;
      dir    <= DIR_RIGHT;
      sl     <= 1'b0;
      sr     <= 1'b0;
      din    <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shadow <= in_data;
            dir    <= shift_dir_e'(in_dir);
            cnt    <= '0;
            state  <= SHIFT;
            sl     <= in_dir;
            sr     <= !in_dir;
            din    <= in_dir ? in_data[WIDTH-1] : in_data[0];
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            sl    <= 1'b0;
            sr    <= 1'b0;
            din   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (dir == DIR_LEFT) begin
              din    <= shadow[WIDTH-2];
              shadow <= shadow << 1;
            end else begin
              din    <= shadow[1];
              shadow <= shadow >> 1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slsr_loader.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_slsr_loader: loader driving a behavioural slsr register.  Rev 1.0
// ---------------------------------------------------------------------
module tb_slsr_loader;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_dir = 1'b0;
  logic         sl, sr, din, done;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;

  slsr_loader #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dir(in_dir), .sl(sl), .sr(sr), .din(din), .done(done)
  );

  // Behavioural slsr register: sr inserts at the top, sl at the bottom.
  logic [W-1:0] q = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sr)      q <= {din, q[W-1:1]};
    else if (sl) q <= {q[W-2:0], din};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted word becomes a schedule of per-cycle outputs.
  typedef struct packed {
    logic         sl, sr, din, done;
    logic [W-1:0] word;
  } exp_t;

  exp_t mq[$];
  exp_t cur = '0;

  function automatic bit model_idle();
    return !(cur.sl || cur.sr || cur.done) && (mq.size() == 0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      cur = '0;
    end else if (model_idle() && in_valid) begin
      for (int k = 0; k < W; k++) begin
        exp_t e;
        e = '0;
        e.sl  = in_dir;
        e.sr  = !in_dir;
        e.din = in_dir ? in_data[3'(W-1-k)] : in_data[3'(k)];
        mq.push_back(e);
      end
      begin
        exp_t d;
        d = '0;
        d.done = 1'b1;
        d.word = in_data;
        mq.push_back(d);
      end
      cur = mq.pop_front();
    end else if (mq.size() != 0) begin
      cur = mq.pop_front();
    end else begin
      cur = '0;
    end
  end

  logic [W-1:0] done_q[$];
  int           done_t[$];

  always @(negedge clk) begin
    if (checking) begin
      chk("m_sl", sl, cur.sl);
      chk("m_sr", sr, cur.sr);
      chk("m_din", din, cur.din);
      chk("m_done", done, cur.done);
      chk("m_ready", in_ready, !reset && model_idle());
      chk("sl_sr_exclusive", sl && sr, 0);
      if (cur.done) chk("m_q_at_done", q, cur.word);
      if (done) begin
        done_q.push_back(q);
        done_t.push_back(cyc);
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!done) chk("done_timeout", done, 1);
  endtask

  // Load one word and return the din bits in emission order (first in MSB).
  task automatic load_word(input logic [W-1:0] d, input logic dir, output logic [W-1:0] emit);
    emit = '0;
    wait_ready();
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      emit = {emit[W-2:0], din};
      chk("lw_dir", {sl, sr}, dir ? 2'b10 : 2'b01);
    end
    @(negedge clk);
    chk("lw_done_hi", done, 1);
    chk("lw_q", q, d);
    chk("lw_ready_lo", in_ready, 0);
    @(negedge clk);
    chk("lw_done_lo", done, 0);
    chk("lw_ready_back", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] emit;
    int n0;

    // Reset state
    @(posedge clk);
    checking = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_outs", {sl, sr, din, done}, 4'b0000);
    @(negedge clk);
    #1 reset = 1'b0;

    // Right shift, LSB first
    load_word(8'hA5, 1'b0, emit);
    chk("a5_din_seq", emit, 8'b1010_0101);

    // Left shift, MSB first, then register holds
    load_word(8'h3C, 1'b1, emit);
    chk("3c_din_seq", emit, 8'b0011_1100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("3c_hold_q", q, 8'h3C);
      chk("3c_hold_ctl", {sl, sr}, 2'b00);
    end

    // Second word offered during SHIFT is taken only when ready
    wait_ready();
    #1;
    in_valid = 1'b1;
    in_data  = 8'hF0;
    in_dir   = 1'b0;
    @(posedge clk);
    #1 in_data = 8'h0F;
    wait_done();
    chk("f0_q", q, 8'hF0);
    @(negedge clk);
    chk("f0_ready_e9", in_ready, 1);
    chk("f0_idle_ctl", {sl, sr}, 2'b00);
    wait_done();
    #1 in_valid = 1'b0;
    chk("0f_q", q, 8'h0F);
    chk("0f_spacing", done_t[$] - done_t[$-1], 10);

    // Reset mid-shift after three shifts; reset wins over in_valid
    load_word(8'h00, 1'b0, emit);
    wait_ready();
    #1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_dir   = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h81;
    @(negedge clk);
    chk("rs_ready_lo", in_ready, 0);
    @(negedge clk);
    chk("rs_outs", {sl, sr, din, done}, 4'b0000);
    chk("rs_q_partial", q, 8'b1110_0000);
    @(negedge clk);
    chk("rs_q_hold", q, 8'b1110_0000);
    chk("rs_no_accept", {sl, sr}, 2'b00);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1 chk("rs_ready_after", in_ready, 1);
    load_word(8'h81, 1'b0, emit);
    chk("81_q", q, 8'h81);

    // Back-to-back words with in_valid held high
    n0 = done_t.size();
    wait_ready();
    #1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_dir   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 in_data = (i % 2 == 0) ? 8'hAA : 8'h55;
      if (i == 2) in_valid = 1'b0;
      else        wait_ready();
    end
    wait_ready();
    #1;
    chk("b2b_count", done_t.size() - n0, 3);
    if (done_t.size() - n0 == 3) begin
      chk("b2b_q0", done_q[n0], 8'h55);
      chk("b2b_q1", done_q[n0+1], 8'hAA);
      chk("b2b_q2", done_q[n0+2], 8'h55);
      chk("b2b_gap0", done_t[n0+1] - done_t[n0], 10);
      chk("b2b_gap1", done_t[n0+2] - done_t[n0+1], 10);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
